// File: rtl/freq_meter_pkg.sv
// ---------------------------------------------------------------------------
// freq_meter_pkg
// Shared definitions for the frequency meter: measurement state encoding and
// default constants used as parameter defaults by freq_meter and
// sync_edge_detect.
// Ports: none (package).
// ---------------------------------------------------------------------------
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } state_t;

  localparam int unsigned CLK_HZ              = 100_000_000;
  // Eighth of a second at 100 MHz without an edge means the signal is gone.
  localparam int unsigned DEFAULT_TIMEOUT     = CLK_HZ / 8;
  localparam int unsigned DEFAULT_MIN_PERIOD  = 4;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous slow signal into the basys_clk domain through a
// flop chain and produces a registered one-cycle pulse on each rising edge.
// All flops reset to 1 so an input already high at reset release does not
// look like a rising edge.
// Ports:
//   basys_clk  in   system clock
//   rst_n      in   synchronous active-low reset
//   async_in   in   asynchronous input
//   rise_pulse out  one-cycle pulse, SYNC_STAGES+1 cycles after an async_in rise
// ---------------------------------------------------------------------------
module sync_edge_detect
  import freq_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic basys_clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  // Synchronizer chain, previous-sample flop and registered edge pulse.
  always_ff @(posedge basys_clk) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign rise_pulse = r_rise;

endmodule

// File: rtl/freq_meter.sv
// ---------------------------------------------------------------------------
// freq_meter
// Measures the rising-to-rising period of a slow asynchronous square wave in
// basys_clk cycles. Each new period is reported with a one-cycle strobe;
// locked shows that a valid measurement exists, timeout shows that no edge
// has arrived for TIMEOUT cycles.
// Optional build macro: FREQ_METER_GLITCH_FILTER_EN -- when defined, edges
// closer than MIN_PERIOD cycles to the previous accepted edge are ignored.
// Ports:
//   basys_clk     in   system clock (100 MHz)
//   rst_n         in   synchronous active-low reset
//   sig_in        in   asynchronous signal to measure
//   period        out  last measured period [CNT_W]
//   period_valid  out  one-cycle strobe when period updates
//   locked        out  a period has been measured and no timeout since
//   timeout       out  signal declared lost
// ---------------------------------------------------------------------------
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned MIN_PERIOD  = DEFAULT_MIN_PERIOD
) (
  input  logic             basys_clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

`ifdef FREQ_METER_GLITCH_FILTER_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  // Compared against the current count so that LOST and a count of
  // TIMEOUT-1 become visible in the same cycle.
  localparam logic [CNT_W-1:0] CNT_LOSE = CNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);

  state_t           r_state;
  logic             r_measured;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_locked;
  logic             r_timeout;

  logic             w_edge;
  logic [CNT_W-1:0] w_cntInc;
  logic             w_shortGap;
  logic             w_reject;
  logic             w_accept;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .basys_clk  (basys_clk),
    .rst_n      (rst_n),
    .async_in   (sig_in),
    .rise_pulse (w_edge)
  );

  // cnt+1 is the period that would be reported if this cycle holds an edge.
  assign w_cntInc   = r_cnt + CNT_W'(1);
  assign w_shortGap = (w_cntInc < MIN_P);
  // Only edges inside a running measurement can be rejected as glitches.
  assign w_reject   = GLITCH_EN && (r_state == MEASURE) && w_shortGap;
  assign w_accept   = w_edge && !w_reject;

  // Cycles since the last accepted edge, saturating at TIMEOUT.
  always_ff @(posedge basys_clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= w_cntInc;
    end
  end

  // Measurement FSM with registered outputs. The arming edge records the
  // start reference, so the next accepted edge already yields a period.
  always_ff @(posedge basys_clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_measured <= 1'b0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_state    <= MEASURE;
            r_measured <= 1'b1;
          end
        end
        MEASURE: begin
          if (w_accept) begin
            if (r_measured) begin
              r_period <= w_cntInc;
              r_valid  <= 1'b1;
              r_locked <= 1'b1;
            end else begin
              r_measured <= 1'b1;
            end
          end else if (r_cnt == CNT_LOSE) begin
            r_state    <= LOST;
            r_locked   <= 1'b0;
            r_timeout  <= 1'b1;
            r_measured <= 1'b0;
          end
        end
        LOST: begin
          if (w_edge) begin
            r_state    <= MEASURE;
            r_measured <= 1'b1;
            r_timeout  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign locked       = r_locked;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_freq_meter
// Drives freq_meter with directed and randomized square waves, compares all
// outputs every cycle against a reference model built on edge arrival times.
// ---------------------------------------------------------------------------
module tb_freq_meter;

  localparam int TIMEOUT = 1000;
  localparam int SYNC    = 2;
  localparam int MINP    = 4;
`ifdef FREQ_METER_GLITCH_FILTER_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif

  logic        basys_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        sig_in    = 1'b1;
  logic [31:0] period;
  logic        period_valid;
  logic        locked;
  logic        timeout;

  int testCount = 0;
  int failCount = 0;
  int cyc       = 0;

  // Reference model: times at which edges become visible at the outputs.
  int          edgeQ[$];
  bit          prevSig    = 1'b1;
  int          mState     = 0;
  int          mLastEdge  = 0;
  logic [31:0] expPeriod  = '0;
  bit          expValid   = 1'b0;
  bit          expLocked  = 1'b0;
  bit          expTimeout = 1'b0;

  freq_meter #(
    .CNT_W       (32),
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (SYNC),
    .MIN_PERIOD  (MINP)
  ) dut (
    .basys_clk    (basys_clk),
    .rst_n        (rst_n),
    .sig_in       (sig_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 basys_clk = ~basys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    edgeQ.delete();
    prevSig    = 1'b1;
    mState     = 0;
    expPeriod  = '0;
    expValid   = 1'b0;
    expLocked  = 1'b0;
    expTimeout = 1'b0;
  endtask

  // mState: 0 idle, 1 measuring (reference edge known), 2 lost.
  task automatic modelStep();
    bit accepted = 1'b0;
    int gap;
    expValid = 1'b0;
    if (edgeQ.size() > 0 && edgeQ[0] == cyc) begin
      void'(edgeQ.pop_front());
      gap = cyc - mLastEdge;
      if (mState != 1) begin
        mState     = 1;
        expTimeout = 1'b0;
        mLastEdge  = cyc;
        accepted   = 1'b1;
      end else if (!(GLITCH && gap < MINP)) begin
        expPeriod = 32'(gap);
        expValid  = 1'b1;
        expLocked = 1'b1;
        mLastEdge = cyc;
        accepted  = 1'b1;
      end
    end
    if (!accepted && mState == 1 && (cyc - mLastEdge) == TIMEOUT - 1) begin
      mState     = 2;
      expLocked  = 1'b0;
      expTimeout = 1'b1;
    end
  endtask

  // One clock cycle of stimulus followed by a full output comparison.
  task automatic applyStimulus(input logic s, input logic r);
    sig_in = s;
    rst_n  = r;
    @(posedge basys_clk);
    cyc++;
    if (!r) begin
      modelReset();
    end else begin
      if (s && !prevSig) edgeQ.push_back(cyc + SYNC + 1);
      prevSig = s;
    end
    #1;
    if (r) modelStep();
    checkOutput("period",       period,              expPeriod);
    checkOutput("period_valid", 32'(period_valid),   32'(expValid));
    checkOutput("locked",       32'(locked),         32'(expLocked));
    checkOutput("timeout",      32'(timeout),        32'(expTimeout));
  endtask

  task automatic holdCycles(input logic s, input int n);
    repeat (n) applyStimulus(s, 1'b1);
  endtask

  // One rising-to-rising interval of p cycles, starting with the rise.
  task automatic risePeriod(input int p);
    holdCycles(1'b1, p / 2);
    holdCycles(1'b0, p - p / 2);
  endtask

  initial begin
    int p;
    // Reset with the input already high, then 100 quiet cycles.
    repeat (5) applyStimulus(1'b1, 1'b0);
    holdCycles(1'b1, 100);

    // 250-cycle wave, six rises: arm then five strobes.
    holdCycles(1'b0, 125);
    repeat (6) risePeriod(250);

    // Stop toggling until the signal is declared lost.
    holdCycles(1'b0, 1100);

    // Re-arm, then intervals 180, 400, 300, 300.
    risePeriod(180);
    risePeriod(400);
    risePeriod(300);
    risePeriod(300);

    // Interval of TIMEOUT-1 is still measured; TIMEOUT times out.
    risePeriod(999);
    risePeriod(1000);
    risePeriod(250);
    risePeriod(250);

    // Randomized intervals.
    repeat (12) begin
      p = int'($urandom_range(8, 700));
      risePeriod(p);
    end

    // Reset 120 cycles after an edge, then two rises before a strobe.
    holdCycles(1'b0, 10);
    holdCycles(1'b1, SYNC + 1 + 120);
    applyStimulus(1'b1, 1'b0);
    holdCycles(1'b1, 20);
    holdCycles(1'b0, 50);
    risePeriod(200);
    risePeriod(200);
    risePeriod(200);

    // Two-cycle glitch one cycle after each real rise of a 250-cycle wave.
    holdCycles(1'b0, 125);
    repeat (3) begin
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      holdCycles(1'b1, 2);
      holdCycles(1'b1, 121);
      holdCycles(1'b0, 125);
    end
    holdCycles(1'b0, 50);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measuring end of the team's clock-divider outputs: takes a slow, asynchronous square wave (for example the 400 Hz divider output or an external pin) and reports its period in basys_clk cycles.
- Used for self-check of divider outputs and for display of measured frequency on the 7-seg/OLED path.
- Reports each new period with a one-cycle valid strobe, plus locked and timeout status.

Parameters:
- CNT_W, 32, width of the internal counter and of the period output.
- TIMEOUT, 12_500_000, number of basys_clk cycles without a rising edge before the signal is declared lost. Must be less than 2^CNT_W.
- SYNC_STAGES, 2, number of synchronizer flops on sig_in. Minimum 2.
- MIN_PERIOD, 4, glitch-reject threshold in cycles. Used only with the optional feature.

Ports:
- basys_clk  input  1  system clock, 100 MHz.
- rst_n  input  1  reset, synchronous, active-low.
- sig_in  input  1  asynchronous slow signal to measure.
- period  output  CNT_W  last measured rising-to-rising period, in basys_clk cycles.
- period_valid  output  1  one-cycle strobe when period updates.
- locked  output  1  high while at least one period has been measured and no timeout has occurred since.
- timeout  output  1  high while in the LOST state.

Behaviour:
- Clocking and reset: one clock, basys_clk. Reset is synchronous, active-low on rst_n. All state updates on posedge basys_clk.
- Reset values: period=0, period_valid=0, locked=0, timeout=0, cnt=0, state=IDLE. Synchronizer and previous-sample flops reset to 1, so an input already high at reset release produces no spurious rising edge.
- Edge detection: `edge` = synchronized sample high AND previous sample low.
  - Latency from a sig_in rise to `edge` is SYNC_STAGES+1 cycles.
  - Fall edges are ignored.
- Counter cnt:
  - Cleared to 0 in any cycle where `edge` is high.
  - Otherwise increments by 1, saturating at TIMEOUT.
- State machine:
  - IDLE: `edge` goes to MEASURE (arm only, no output).
  - MEASURE with `edge` and measured flag set:
    - period <= cnt+1 and period_valid=1, both in the next cycle.
    - locked=1 from that cycle.
  - MEASURE with `edge` and measured flag clear: set the flag, no output.
  - MEASURE with cnt reaching TIMEOUT-1 and no `edge`: go to LOST.
    - locked=0, timeout=1, and the measured flag clears.
    - period holds its last value.
  - LOST: `edge` goes to MEASURE with timeout=0. This first edge only arms, same as in IDLE.
- Simultaneous events: `edge` in the same cycle cnt reaches TIMEOUT-1 counts as an edge. The period is reported and there is no timeout.
- Timing rules:
  - period_valid is never high for two consecutive cycles.
  - period is stable whenever period_valid is low.
- Reset mid-operation: rst_n low forces all reset values on the next clock, regardless of state. Any partial count is discarded.
- Width rules: cnt+1 is computed in CNT_W bits. It cannot overflow because TIMEOUT < 2^CNT_W.

Optional Feature:
- Macro: FREQ_METER_GLITCH_FILTER_EN.
- When defined: in MEASURE, an `edge` with cnt+1 < MIN_PERIOD is ignored entirely. cnt keeps counting and there is no period_valid.
- When undefined: every `edge` is accepted. MIN_PERIOD is unused.

Decomposition:
- Package freq_meter_pkg holds:
  - State enum: IDLE, MEASURE, LOST.
  - Default constants: CLK_HZ=100_000_000, DEFAULT_TIMEOUT, DEFAULT_MIN_PERIOD.
- Sub-module sync_edge_detect: parameter SYNC_STAGES, inputs basys_clk, rst_n, async_in, output rise_pulse. It contains the synchronizer chain (reset to 1) and the rising-edge detector.

Test Plan:
- Reset release with sig_in=1, held high for 100 cycles: no period_valid, state IDLE, all outputs 0.
- TIMEOUT=1000, square wave with period 250 cycles, 6 rises: first rise arms only. Then 5 period_valid pulses with period=250 each, locked=1 after the 2nd rise, pulse spacing exactly 250 cycles.
- TIMEOUT=1000, stop toggling after lock: timeout=1 and locked=0 exactly 1000-1 cycles after the last `edge`, period still 250. Next rise gives timeout=0 and no strobe; the following rise gives period = actual spacing.
- Input period 400 then 300 cycles: period reads 400, then 300, each with a single-cycle strobe.
- Assert rst_n=0 mid-count, 120 cycles after an edge: all outputs 0 next cycle. After release, two further rises are needed before the first strobe.
- FREQ_METER_GLITCH_FILTER_EN with MIN_PERIOD=4: inject a 2-cycle pulse 1 cycle after a real edge on a 250-cycle wave. It is ignored and period=250.
  - Same stimulus without the macro: period=2 or 3 is reported, then the remainder of the interval.
